// File: rtl/prbs_pkg.sv
// Shared constants, state type and seed helper for the PRBS word server.
package prbs_pkg;

    localparam int unsigned LFSR_W = 11;
    localparam logic [LFSR_W-1:0] LFSR_LOCKUP = 11'h7FF;
    localparam int unsigned TAP_A = 0;
    localparam int unsigned TAP_B = 2;

    typedef enum logic {
        StFill,
        StReady
    } state_e;

    // The all-ones state is a fixed point of the XNOR feedback, so never load it.
    function automatic logic [LFSR_W-1:0] sanitise_seed(input logic [LFSR_W-1:0] seed);
        return (seed == LFSR_LOCKUP) ? '0 : seed;
    endfunction

endpackage

// File: rtl/lfsr11.sv
// 11-bit right-shifting XNOR LFSR with step enable and synchronous seed load.
module lfsr11
    import prbs_pkg::*;
(
    input  logic              Clock,
    input  logic              nReset,
    input  logic              Step,
    input  logic              Load,
    input  logic [LFSR_W-1:0] Seed,
    output logic [LFSR_W-1:0] Q
);

    logic [LFSR_W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (Load) begin
            q_d = sanitise_seed(Seed);
        end else if (Step) begin
            q_d = {q_q[TAP_A] ^ ~q_q[TAP_B], q_q[LFSR_W-1:1]};
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/prbs_server.sv
// Assembles W-bit words from an LFSR two bits per cycle and hands each word to one
// requester via round-robin arbitration with a registered one-cycle Ack.
module prbs_server
    import prbs_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic [NREQ-1:0]   Req,
    output logic [NREQ-1:0]   Ack,
    output logic [W-1:0]      Data,
    input  logic              SeedLoad,
    input  logic [LFSR_W-1:0] Seed,
    output logic              Avail
);

    localparam int unsigned Steps = W / 2;
    localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;
    localparam int unsigned IdxW  = $clog2(NREQ);
    localparam logic [CntW-1:0] CntLast = CntW'(Steps - 1);
    localparam logic [IdxW-1:0] IdxMax  = IdxW'(NREQ - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]      buf_q, buf_d;
    logic [W-1:0]      data_q, data_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [IdxW-1:0]   last_q, last_d;

    logic              step;
    logic [LFSR_W-1:0] lfsr_q;
    logic [1:0]        ran;
    logic              grant_found;
    logic [IdxW-1:0]   grant_idx;
    logic              unused_lfsr;

    lfsr11 u_lfsr (
        .Clock  (Clock),
        .nReset (nReset),
        .Step   (step),
        .Load   (SeedLoad),
        .Seed   (Seed),
        .Q      (lfsr_q)
    );

    assign ran         = lfsr_q[1:0];
    assign unused_lfsr = ^lfsr_q[LFSR_W-1:2];

    function automatic logic [IdxW-1:0] rr_index(input logic [IdxW-1:0] base,
                                                 input int unsigned off);
        int unsigned c;
        c = (32'(base) + off) % NREQ;
        return IdxW'(c);
    endfunction

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_q;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            if (!grant_found && Req[rr_index(last_q, i)]) begin
                grant_found = 1'b1;
                grant_idx   = rr_index(last_q, i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        data_d  = data_q;
        ack_d   = '0;
        last_d  = last_q;
        step    = 1'b0;

        if (SeedLoad) begin
            state_d = StFill;
            cnt_d   = '0;
            buf_d   = '0;
        end else begin
            unique case (state_q)
                StFill: begin
                    step  = 1'b1;
                    buf_d = {ran, buf_q[W-1:2]};
                    if (cnt_q == CntLast) begin
                        state_d = StReady;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StReady: begin
                    if (grant_found) begin
                        ack_d[grant_idx] = 1'b1;
                        data_d           = buf_q;
                        last_d           = grant_idx;
                        cnt_d            = '0;
                        state_d          = StFill;
                    end
                end
                default: state_d = StFill;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= StFill;
            cnt_q   <= '0;
            buf_q   <= '0;
            data_q  <= '0;
            ack_q   <= '0;
            last_q  <= IdxMax;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            last_q  <= last_d;
        end
    end

    assign Ack   = ack_q;
    assign Data  = data_q;
    assign Avail = (state_q == StReady);

endmodule

// File: tb/tb_prbs_server.sv
// Directed bench for prbs_server with a word-level reference model checked every cycle.
module tb_prbs_server;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic            Clock;
    logic            nReset;
    logic [NREQ-1:0] Req;
    logic [NREQ-1:0] Ack;
    logic [W-1:0]    Data;
    logic            SeedLoad;
    logic [10:0]     Seed;
    logic            Avail;

    int checks = 0;
    int errors = 0;

    prbs_server #(
        .NREQ (NREQ),
        .W    (W)
    ) dut (
        .Clock    (Clock),
        .nReset   (nReset),
        .Req      (Req),
        .Ack      (Ack),
        .Data     (Data),
        .SeedLoad (SeedLoad),
        .Seed     (Seed),
        .Avail    (Avail)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Reference model: each word is computed whole when its fill begins; Avail is simply
    // "the fill countdown has run out".
    int              m_q;
    int              m_word;
    int              m_rem;
    int              m_last;
    logic [NREQ-1:0] m_ack;
    logic [W-1:0]    m_data;

    task automatic start_word();
        int q, w, fb;
        q = m_q;
        w = 0;
        for (int k = 0; k < W / 2; k++) begin
            w  = (w >> 2) | ((q % 4) << (W - 2));
            fb = (q & 1) ^ (((q >> 2) & 1) ^ 1);
            q  = (q >> 1) | (fb << 10);
        end
        m_word = w;
        m_q    = q;
        m_rem  = W / 2;
    endtask

    task automatic model_reset();
        m_q    = 0;
        m_last = NREQ - 1;
        m_ack  = '0;
        m_data = '0;
        start_word();
    endtask

    task automatic model_step();
        int  g;
        bit  found;
        found = 0;
        g     = 0;
        if (SeedLoad) begin
            m_q   = (Seed == 11'h7FF) ? 0 : int'(Seed);
            m_ack = '0;
            start_word();
        end else if (m_rem == 0 && Req != 0) begin
            for (int i = 1; i <= NREQ; i++) begin
                if (!found && Req[(m_last + i) % NREQ]) begin
                    found = 1;
                    g     = (m_last + i) % NREQ;
                end
            end
            m_ack  = NREQ'(1 << g);
            m_data = W'(m_word);
            m_last = g;
            start_word();
        end else begin
            m_ack = '0;
            if (m_rem > 0) m_rem--;
        end
    endtask

    always begin
        @(posedge Clock);
        if (!nReset) model_reset();
        else model_step();
        #1;
        chk("model_ack", 32'(Ack), 32'(m_ack));
        chk("model_data", 32'(Data), 32'(m_data));
        chk("model_avail", 32'(Avail), 32'(m_rem == 0));
    end

    task automatic do_reset(input logic [NREQ-1:0] r);
        @(negedge Clock);
        nReset   = 1'b0;
        Req      = r;
        SeedLoad = 1'b0;
        Seed     = '0;
        repeat (2) @(negedge Clock);
        nReset = 1'b1;
    endtask

    task automatic wait_ack(input int limit, output int n, output logic [NREQ-1:0] a,
                            output logic [W-1:0] d);
        n = 0;
        a = '0;
        d = '0;
        while (n < limit && a == '0) begin
            @(posedge Clock);
            #1;
            n++;
            a = Ack;
            d = Data;
        end
        if (a == '0) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no Ack within %0d cycles at %0t", limit, $time);
        end
    endtask

    logic [W-1:0] t1_exp [3] = '{8'h00, 8'h00, 8'hE0};
    int           t2_ord [5] = '{0, 1, 2, 3, 0};

    initial begin
        int              n;
        logic [NREQ-1:0] a;
        logic [W-1:0]    d;

        nReset   = 1'b0;
        Req      = '0;
        SeedLoad = 1'b0;
        Seed     = '0;

        // Reset values, then three grants to requester 0.
        do_reset(4'b0001);
        chk("rst_ack", 32'(Ack), 32'h0);
        chk("rst_data", 32'(Data), 32'h0);
        chk("rst_avail", 32'(Avail), 32'h0);
        for (int k = 0; k < 3; k++) begin
            wait_ack(10, n, a, d);
            chk("t1_spacing", 32'(n), 32'd5);
            chk("t1_ack", 32'(a), 32'h1);
            chk("t1_data", 32'(d), 32'(t1_exp[k]));
        end

        // All requesters continuously: round-robin order.
        do_reset(4'b1111);
        for (int k = 0; k < 5; k++) begin
            wait_ack(10, n, a, d);
            chk("t2_spacing", 32'(n), 32'd5);
            chk("t2_onehot", 32'($onehot(a)), 32'd1);
            chk("t2_order", 32'(a), 32'(1 << t2_ord[k]));
        end

        // Lock-up seed is replaced by zero.
        do_reset(4'b0000);
        repeat (6) @(negedge Clock);
        SeedLoad = 1'b1;
        Seed     = 11'h7FF;
        @(negedge Clock);
        SeedLoad = 1'b0;
        Req      = 4'b0001;
        wait_ack(10, n, a, d);
        chk("t3_latency", 32'(n), 32'd5);
        chk("t3_data", 32'(d), 32'h00);

        // SeedLoad colliding with a grant.
        do_reset(4'b0000);
        repeat (5) @(negedge Clock);
        chk("t4_ready", 32'(Avail), 32'h1);
        Req      = 4'b0010;
        SeedLoad = 1'b1;
        Seed     = 11'h123;
        @(posedge Clock);
        #1;
        chk("t4_noack", 32'(Ack), 32'h0);
        chk("t4_avail_low", 32'(Avail), 32'h0);
        @(negedge Clock);
        SeedLoad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge Clock);
            #1;
            chk("t4_avail_low", 32'(Avail), 32'h0);
            chk("t4_noack", 32'(Ack), 32'h0);
        end
        @(posedge Clock);
        #1;
        chk("t4_avail_high", 32'(Avail), 32'h1);
        wait_ack(4, n, a, d);
        chk("t4_latency", 32'(n), 32'd1);
        chk("t4_ack", 32'(a), 32'b0010);

        // Request withdrawn during fill leaves the round-robin pointer alone.
        do_reset(4'b0010);
        wait_ack(10, n, a, d);
        chk("t5_first", 32'(a), 32'b0010);
        @(negedge Clock);
        Req = 4'b0100;
        @(negedge Clock);
        @(negedge Clock);
        Req = 4'b0000;
        repeat (3) @(negedge Clock);
        chk("t5_idle_ack", 32'(Ack), 32'h0);
        chk("t5_idle_avail", 32'(Avail), 32'h1);
        Req = 4'b1100;
        wait_ack(4, n, a, d);
        chk("t5_latency", 32'(n), 32'd1);
        chk("t5_ack", 32'(a), 32'b0100);

        // Asynchronous reset in the middle of an Ack cycle.
        do_reset(4'b0001);
        for (int k = 0; k < 3; k++) wait_ack(10, n, a, d);
        chk("t6_pre_data", 32'(d), 32'hE0);
        #2;
        nReset = 1'b0;
        #1;
        chk("t6_ack_cleared", 32'(Ack), 32'h0);
        chk("t6_data_cleared", 32'(Data), 32'h0);
        chk("t6_avail_cleared", 32'(Avail), 32'h0);
        repeat (2) @(negedge Clock);
        nReset = 1'b1;
        wait_ack(10, n, a, d);
        chk("t6_latency", 32'(n), 32'd5);
        chk("t6_data", 32'(d), 32'h00);

        @(negedge Clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule
